// File: rtl/spart_tx_unit_pkg.sv
// spart_tx_unit_pkg: shared processor package content for the SPART
// transmitter. Holds the serializer state encoding and the bit positions of
// the SPART status word; the writeback source mux decode imports the same
// constants so both sides agree on the layout.
package spart_tx_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // status word layout
  localparam int ST_CNT_LO = 0;
  localparam int ST_CNT_HI = 2;
  localparam int ST_EMPTY  = 3;
  localparam int ST_FULL   = 4;
  localparam int ST_BUSY   = 5;
  localparam int ST_W      = 16;

  localparam int TX_BITS   = 8;

endpackage

// File: rtl/spart_tx_unit_fifo.sv
// spart_tx_fifo: circular byte FIFO for the SPART transmitter.
// Ports:
//   clk, rst        clock, async active-high reset (clears pointers/count)
//   push_i, data_i  write request and byte; ignored while full
//   pop_i, data_o   read request and head byte (data_o valid when !empty_o)
//   count_o         occupancy 0..DEPTH
//   full_o, empty_o occupancy flags from the registered count
module spart_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a push at full is
  // refused even when a pop frees a slot on the same edge.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spart_tx_unit.sv
// spart_tx_unit: SPART transmit path. Stores from the MEM stage go into a
// small FIFO; a serializer drains it as 8N1 frames on txd.
// Ports:
//   clk, rst   clock, async active-high reset (aborts any frame, drops queue)
//   wr_en      store request; wr_byte is the byte to send
//   stall      store refused this cycle (FIFO full), pipeline holds it
//   status     {10'b0, busy, full, empty, count[2:0]} for the writeback mux
//   txd        registered serial output, idle high
module spart_tx_unit
  import spart_tx_unit_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_byte,
  output logic            stall,
  output logic [ST_W-1:0] status,
  output logic            txd
);

  localparam int          CW          = $clog2(DEPTH + 1);
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          pop;
  logic          baud_done;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [2:0]    cnt3;

  spart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .data_i  (wr_byte),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign stall     = wr_en & full;
  assign baud_done = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(TX_BITS - 1)) state_d = STOP;
          else                          bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is decoded from the next state and registered, so the line
    // changes only on clock edges and tracks the state without lag.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd = txd_q;

  // Only the low three count bits are shown in the status word.
  if (CW >= 3) begin : g_cnt_wide
    assign cnt3 = count[2:0];
  end else begin : g_cnt_narrow
    assign cnt3 = 3'(count);
  end

  always_comb begin
    status                      = '0;
    status[ST_CNT_HI:ST_CNT_LO] = cnt3;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_BUSY]             = (state_q != IDLE);
  end

endmodule

// File: tb/tb_spart_tx_unit.sv
// Directed bench for spart_tx_unit with BAUD_DIV=4, DEPTH=4.
module tb_spart_tx_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_byte;
  logic        stall;
  logic [15:0] status;
  logic        txd;

  int ncmp = 0;
  int nerr = 0;

  spart_tx_unit #(.BAUD_DIV(4), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_byte (wr_byte),
    .stall   (stall),
    .status  (status),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line receiver: frame cycle 0 is the first low cycle; bit i is sampled
  // mid-bit at cycle 4*i+6, the byte is logged mid-STOP.
  int         cyc = 0;
  bit         rx_on = 1'b0;
  int         rx_c = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         st_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst === 1'b1) rx_on = 1'b0;
    else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1'b1;
        rx_c  = 0;
        st_q.push_back(cyc);
      end
    end else begin
      rx_c++;
      if (rx_c >= 6 && rx_c <= 34 && ((rx_c - 6) % 4) == 0) rx_sh[3'((rx_c - 6) / 4)] = txd;
      if (rx_c == 38) rx_q.push_back(rx_sh);
      if (rx_c == 39) rx_on = 1'b0;
    end
  end

  // Checks txd/status for the 40 cycles of a frame starting at the next negedge.
  task automatic frame_chk(input logic [7:0] b, input logic [15:0] st);
    logic e;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 4)       e = 1'b0;
      else if (c < 36) e = b[3'((c - 4) / 4)];
      else             e = 1'b1;
      chk($sformatf("frame_txd_c%0d", c), 32'(txd), 32'(e));
      chk($sformatf("frame_busy_c%0d", c), 32'(status), 32'(st));
    end
  endtask

  logic [7:0] exp7[7] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h66};
  logic [7:0] sb[16];
  int n;
  int idx;

  initial begin
    rst = 1'b1; wr_en = 1'b1; wr_byte = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_status", 32'(status), 32'h0008);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_txd", 32'(txd), 32'd1);
      chk("idle_status", 32'(status), 32'h0008);
      chk("idle_stall", 32'(stall), 32'd0);
    end

    // single byte
    wr_en = 1'b1; wr_byte = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("a5_queued", 32'(status), 32'h0001);
    frame_chk(8'hA5, 16'h0028);
    @(negedge clk);
    chk("a5_done_status", 32'(status), 32'h0008);
    chk("a5_done_txd", 32'(txd), 32'd1);

    // five back-to-back pushes, then a sixth into a full FIFO
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_byte = 8'(i);
      @(negedge clk);
    end
    chk("burst_status", 32'(status), 32'h0034);
    wr_byte = 8'h06;
    #1 chk("burst_6th_stall", 32'(stall), 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    chk("burst_6th_dropped", 32'(status), 32'h0034);

    // push on the pop cycle while full: refused, count drops to 3
    n = 0;
    while (status[5] && n < 200) begin @(negedge clk); n++; end
    chk("wait_idle1", 32'(n), 32'd36);
    chk("idle_full_status", 32'(status), 32'h0014);
    wr_en = 1'b1; wr_byte = 8'h77;
    #1 chk("pop_full_stall", 32'(stall), 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    chk("pop_full_count3", 32'(status), 32'h0023);

    n = 0;
    while (status[5] && n < 200) begin @(negedge clk); n++; end
    chk("wait_idle2", 32'(n), 32'd40);
    chk("idle_cnt3_status", 32'(status), 32'h0003);
    @(negedge clk);
    n = 0;
    while (status[5] && n < 200) begin @(negedge clk); n++; end
    chk("wait_idle3", 32'(n), 32'd40);
    chk("idle_cnt2_status", 32'(status), 32'h0002);
    // push on the pop cycle at count 2: count stays 2
    wr_en = 1'b1; wr_byte = 8'h66;
    #1 chk("pop_cnt2_stall", 32'(stall), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    chk("pop_cnt2_count", 32'(status), 32'h0022);

    n = 0;
    while (status !== 16'h0008 && n < 1000) begin @(negedge clk); n++; end
    chk("drain1_status", 32'(status), 32'h0008);
    chk("rx1_size", 32'(rx_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("rx1_byte%0d", i), 32'((i < rx_q.size()) ? rx_q[i] : 8'hXX), 32'(exp7[i]));
    for (int i = 2; i < 7; i++)
      chk($sformatf("rx1_gap%0d", i), 32'((i < st_q.size()) ? st_q[i] - st_q[i-1] : 0), 32'd41);

    // reset during DATA bit 3 of 8'hFF with two bytes queued
    rx_q.delete(); st_q.delete();
    wr_en = 1'b1; wr_byte = 8'hFF;
    @(negedge clk); wr_byte = 8'h11;
    @(negedge clk); wr_byte = 8'h22;
    @(negedge clk); wr_en = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_status", 32'(status), 32'h0022);
    chk("pre_rst_txd", 32'(txd), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_status", 32'(status), 32'h0008);
    chk("midrst_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("postrst_txd", 32'(txd), 32'd1);
      chk("postrst_status", 32'(status), 32'h0008);
    end
    chk("postrst_no_frames", 32'(rx_q.size()), 32'd0);

    // continuous 16-byte stream
    rx_q.delete(); st_q.delete();
    for (int i = 0; i < 16; i++) sb[i] = 8'(i * 29 + 7);
    idx = 0; n = 0;
    while (idx < 16 && n < 2000) begin
      wr_en = 1'b1; wr_byte = sb[idx];
      #1;
      if (!stall) idx++;
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    chk("stream_all_pushed", 32'(idx), 32'd16);
    n = 0;
    while (status !== 16'h0008 && n < 2000) begin @(negedge clk); n++; end
    chk("stream_drain_status", 32'(status), 32'h0008);
    chk("stream_rx_size", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("stream_byte%0d", i), 32'((i < rx_q.size()) ? rx_q[i] : 8'hXX), 32'(sb[i]));
    for (int i = 1; i < 16; i++)
      chk($sformatf("stream_gap%0d", i), 32'((i < st_q.size()) ? st_q[i] - st_q[i-1] : 0), 32'd41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/spart_tx_unit.md
SPART_TX_UNIT -- requirements
Module: spart_tx_unit

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434: clock cycles per serial bit period (legal range 2..65535).
REQ-002 SHALL have parameter DEPTH, default 4: transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: SPART store request from the MEM stage.
REQ-006 SHALL have port wr_byte, input, 8 bits: byte to transmit, already selected by the SPART byte-select mux.
REQ-007 SHALL have port stall, output, 1 bit: store rejected this cycle; the pipeline holds the store.
REQ-008 SHALL have port status, output, 16 bits: status word fed to the writeback source mux spart input.
REQ-009 SHALL have port txd, output, 1 bit: serial line, idle high.

Function
REQ-010 SHALL hold DEPTH bytes in a circular FIFO with registered read pointer, write pointer and count (0..DEPTH).
REQ-011 SHALL accept a push when wr_en=1 and the registered count < DEPTH; the byte is stored at the next edge.
REQ-012 SHALL drive stall = wr_en AND (count == DEPTH) combinationally; a rejected byte is not stored.
REQ-013 SHALL evaluate full on the registered count: a push at count=DEPTH is rejected even if a pop occurs in the same cycle.
REQ-014 SHALL apply a simultaneous push and pop with count in 1..DEPTH-1 in the same edge, leaving count unchanged.
REQ-015 SHALL wrap both pointers modulo DEPTH.
REQ-016 SHALL run the serializer FSM with states IDLE, START, DATA and STOP.
REQ-017 In IDLE with count>0, the FSM SHALL pop the head byte into the shift register and enter START at the next edge; with count=0 it SHALL remain in IDLE.
REQ-018 SHALL drive txd high in IDLE, low in START, shift-register bit 0 in DATA (LSB first, 8 bits) and high in STOP.
REQ-019 SHALL hold each of START, every DATA bit and STOP for exactly BAUD_DIV cycles, timed by a baud counter reloaded on each bit boundary.
REQ-020 SHALL make one frame occupy exactly 10*BAUD_DIV cycles from START entry to the return to IDLE.
REQ-021 After STOP, the FSM SHALL return to IDLE; if the FIFO is non-empty, the next pop occurs in the IDLE cycle, leaving exactly 1 idle-high cycle between frames.
REQ-022 SHALL register txd so that it is glitch-free.
REQ-023 SHALL form status as: [2:0] = count (saturating display for DEPTH>7 not required at default), [3] = empty (count==0), [4] = full (count==DEPTH), [5] = busy (FSM != IDLE), [15:6] = 0.
REQ-024 SHALL derive status combinationally from registered state.

Reset
REQ-025 rst=1 SHALL asynchronously clear count, both pointers, the baud counter, the bit index and the shift register, set the FSM to IDLE and set txd=1.
REQ-026 With rst=1, the outputs SHALL be stall=0 and status=16'h0008.
REQ-027 A reset mid-frame SHALL abort the frame immediately (txd high, no partial STOP) and discard all queued bytes.
REQ-028 SHALL ignore wr_en while rst=1.

Structure
REQ-029 The FSM state encoding and status bit-index constants SHALL live in the shared processor package, consumed also by the writeback source mux decode.
REQ-030 The FIFO SHALL be one sub-module, spart_tx_fifo, with push/pop/count ports; the serializer FSM and baud counter SHALL stay in the top module.

Verification (BAUD_DIV=4, DEPTH=4)
REQ-031 Reset then idle -> txd=1, status=16'h0008, stall=0 throughout.
REQ-032 Single push 8'hA5 -> txd = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy=1 for 40 cycles; status returns to 16'h0008.
REQ-033 5 back-to-back pushes 8'h01..8'h05 starting in IDLE -> first pops immediately, 4 queued; status=16'h0034 (count=4, full, busy); a 6th push gives stall=1 and is dropped; transmit order 01,02,03,04,05.
REQ-034 Push exactly on the pop cycle with count=4 -> stall=1, count becomes 3; push at count=2 on the pop cycle -> count stays 2.
REQ-035 Assert rst during DATA bit 3 of 8'hFF with 2 bytes queued -> txd=1 in the same cycle, status=16'h0008, no further frames.
REQ-036 Continuous 16-byte stream -> frames separated by exactly 1 idle cycle, pointers wrap correctly, with no lost or duplicated bytes.
